// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Iterative XLEN-bit unsigned multiplier / divider for an
//               in-order pipeline. Shift-add MUL (low half), restoring
//               DIVU/REMU, one iteration per cycle, pipeline stall/flush.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  // Counter value of the final iteration.
  localparam logic [5:0] LAST_ITER = 6'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [5:0]      cnt;
  logic [1:0]      op_q;
  // MUL : a_q = shifting multiplicand, b_q = shifting multiplier, acc_q = product
  // DIV : a_q = divisor, b_q = dividend shifting out / quotient shifting in,
  //       acc_q = partial remainder
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] result_q;

  logic            accept;
  logic            div_op;
  logic            div_by_zero;
  logic            short_path;
  logic [XLEN-1:0] mul_sum;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   rem_diff;
  logic            no_borrow;
  logic [XLEN-1:0] final_val;

  // Rst gates acceptance so stall stays low throughout reset.
  assign accept      = (state == S_IDLE) & start & ~flush & ~rst;
  assign div_op      = (op == OP_DIVU) | (op == OP_REMU);
  assign div_by_zero = div_op & (rs2 == '0);
  assign short_path  = div_by_zero | (op == OP_RSV);

  // One shift-add step and one restoring-division step.
  assign mul_sum   = acc_q + (b_q[0] ? a_q : '0);
  assign rem_shift = {acc_q, b_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, a_q};
  assign no_borrow = ~rem_diff[XLEN];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; flush always wins and returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = short_path ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (cnt == LAST_ITER) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand load on acceptance, then one iteration per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      op_q  <= OP_MUL;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (accept) begin
      cnt  <= '0;
      op_q <= op;
      if (op == OP_RSV) begin
        a_q   <= '0;
        b_q   <= '0;
        acc_q <= '0;
      end else if (div_by_zero) begin
        // Quotient of all ones, remainder equal to the dividend.
        a_q   <= rs2;
        b_q   <= '1;
        acc_q <= rs1;
      end else if (op == OP_MUL) begin
        a_q   <= rs1;
        b_q   <= rs2;
        acc_q <= '0;
      end else begin
        a_q   <= rs2;
        b_q   <= rs1;
        acc_q <= '0;
      end
    end else if (state == S_CALC) begin
      cnt <= cnt + 6'd1;
      if (op_q == OP_MUL) begin
        acc_q <= mul_sum;
        a_q   <= {a_q[XLEN-2:0], 1'b0};
        b_q   <= {1'b0, b_q[XLEN-1:1]};
      end else if (no_borrow) begin
        acc_q <= rem_diff[XLEN-1:0];
        b_q   <= {b_q[XLEN-2:0], 1'b1};
      end else begin
        acc_q <= rem_shift[XLEN-1:0];
        b_q   <= {b_q[XLEN-2:0], 1'b0};
      end
    end
  end

  // Select the finished value for the latched operation.
  always_comb begin
    final_val = '0;
    case (op_q)
      OP_MUL:  final_val = acc_q;
      OP_DIVU: final_val = b_q;
      OP_REMU: final_val = acc_q;
      default: final_val = '0;
    endcase
  end

  // Commit the result at the end of an unflushed done cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else if (done) begin
      result_q <= final_val;
    end
  end

  assign busy  = (state == S_CALC);
  assign stall = accept | busy;
  assign done  = (state == S_DONE) & ~flush;
  // The new value is visible in the done cycle itself; a flushed done cycle
  // keeps showing the previously committed value.
  assign result = done ? final_val : result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Scoreboard bench for muldiv_seq with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            flush;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ndone = 0;

  typedef struct {
    logic [XLEN-1:0] res;
    int              when;
    string           name;
  } exp_t;

  exp_t sbq[$];

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: every done pulse pops the oldest expectation and checks it.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      ndone++;
      if (sbq.size() == 0) begin
        chk_int("done_without_pending_op", sbq.size(), 1);
      end else begin
        e = sbq.pop_front();
        chk(e.name, result, e.res);
        chk_int({e.name, "_cycle"}, cyc, e.when);
      end
    end
  end

  // Issue one op, push its expectation, wait (bounded) for its done pulse
  // and count the stall cycles from acceptance to done.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] req, input int lat);
    int   n;
    int   d0;
    int   stalls;
    int   got;
    exp_t e;
    @(posedge clk); #1;
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    n = cyc; d0 = ndone; stalls = 0; got = 0;
    e.res = req; e.when = n + lat; e.name = nm;
    sbq.push_back(e);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (stall) stalls++;
      if (ndone != d0) begin
        got = 1;
        break;
      end
      if (i == 0) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk_int({nm, "_done_seen"}, got, 1);
    chk_int({nm, "_stall_cycles"}, stalls, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int d0;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_stall", int'(stall), 0);
    chk_int("rst_done", int'(done), 0);
    chk("rst_result", result, '0);
    rst = 1'b0;

    run_op("mul_7x6",      2'b00, 32'd7,          32'd6,          32'h0000002A, 33);
    run_op("mul_ffxff",    2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 33);
    run_op("divu_100_7",   2'b01, 32'd100,        32'd7,          32'd14,       33);
    run_op("remu_100_7",   2'b10, 32'd100,        32'd7,          32'd2,        33);
    run_op("divu_msb_1",   2'b01, 32'h80000000,   32'd1,          32'h80000000, 33);
    run_op("divu_5_0",     2'b01, 32'd5,          32'd0,          32'hFFFFFFFF, 1);
    run_op("remu_5_0",     2'b10, 32'd5,          32'd0,          32'd5,        1);
    run_op("op_reserved",  2'b11, 32'd123,        32'd45,         32'd0,        1);
    run_op("remu_big_16",  2'b10, 32'hFFFFFFFF,   32'd16,         32'd15,       33);
    run_op("mul_wrap",     2'b00, 32'h00010001,   32'h00010000,   32'h00010000, 33);

    // Start held high across CALC and DONE: second op accepted only in IDLE.
    @(posedge clk); #1;
    op = 2'b00; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
    n = cyc; d0 = ndone;
    sbq.push_back('{32'd15, n + 33, "hold_first"});
    sbq.push_back('{32'd15, n + 67, "hold_second"});
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (cyc == n + 34) begin
        chk_int("hold_gap_busy", int'(busy), 0);
        chk_int("hold_gap_stall", int'(stall), 1);
      end
      if (ndone == d0 + 2) break;
    end
    start = 1'b0;
    chk_int("hold_two_dones", ndone - d0, 2);
    @(negedge clk);
    chk_int("hold_idle_busy", int'(busy), 0);
    chk_int("hold_idle_stall", int'(stall), 0);

    // Start and flush together in IDLE: nothing accepted.
    @(posedge clk); #1;
    op = 2'b00; rs1 = 32'd2; rs2 = 32'd2; start = 1'b1; flush = 1'b1; d0 = ndone;
    @(negedge clk);
    chk_int("startflush_stall", int'(stall), 0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk_int("startflush_busy", int'(busy), 0);

    // Flush at iteration 10 of a MUL.
    @(posedge clk); #1;
    op = 2'b00; rs1 = 32'd7; rs2 = 32'd9; start = 1'b1; n = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk_int("flush_busy_during", int'(busy), 1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk_int("flush_busy_after", int'(busy), 0);
    chk_int("flush_stall_after", int'(stall), 0);
    repeat (40) @(negedge clk);
    chk_int("flush_no_done", ndone - d0, 0);
    chk("flush_result_kept", result, 32'd15);
    run_op("mul_3x3", 2'b00, 32'd3, 32'd3, 32'd9, 33);

    // Asynchronous reset in the middle of CALC, start ignored while held.
    @(posedge clk); #1;
    op = 2'b01; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk_int("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk_int("midrst_busy", int'(busy), 0);
    chk_int("midrst_stall", int'(stall), 0);
    chk_int("midrst_done", int'(done), 0);
    chk("midrst_result", result, '0);
    op = 2'b00; rs1 = 32'd4; rs2 = 32'd4; start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_int("rst_start_busy", int'(busy), 0);
    chk_int("rst_start_stall", int'(stall), 0);
    start = 1'b0;
    rst = 1'b0;
    run_op("mul_after_rst", 2'b00, 32'd4, 32'd5, 32'd20, 33);

    repeat (3) @(posedge clk);
    chk_int("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  EX stage requests a multi-cycle op, qualified by op/rs1/rs2 in the same cycle.
REQ-005 SHALL have port: op  input  2  00 MUL (low XLEN bits), 01 DIVU quotient, 10 REMU remainder, 11 reserved.
REQ-006 SHALL have port: rs1  input  XLEN  multiplicand / dividend.
REQ-007 SHALL have port: rs2  input  XLEN  multiplier / divisor.
REQ-008 SHALL have port: flush  input  1  pipeline flush, aborts any op in flight.
REQ-009 SHALL have port: busy  output  1  high in CALC state.
REQ-010 SHALL have port: stall  output  1  freeze IF/ID/EX pipeline registers.
REQ-011 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port: result  output  XLEN  registered result.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; state, 6-bit iteration counter and operand/accumulator registers are the only storage.
REQ-014 SHALL accept start only in IDLE with flush low; start in CALC or DONE is ignored.
REQ-015 SHALL latch op, rs1, rs2 on acceptance, clear counter to 0 and go IDLE->CALC, except per REQ-019/REQ-020.
REQ-016 SHALL, in CALC, do exactly one iteration per cycle: MUL = shift-add (LSB of multiplier adds shifted multiplicand); DIVU/REMU = restoring division (shift remainder left, subtract divisor if no borrow, set quotient bit).
REQ-017 SHALL leave CALC for DONE after the 32nd iteration (counter 31), so done pulses in cycle N+33 for a start accepted in cycle N.
REQ-018 SHALL, in DONE, assert done for exactly one cycle, update result, and return to IDLE next cycle.
REQ-019 SHALL, on DIVU/REMU with rs2 = 0, go IDLE->DONE directly (done in cycle N+1): quotient = all ones, remainder = rs1.
REQ-020 SHALL, on op = 11, go IDLE->DONE directly with result = 0.
REQ-021 SHALL compute MUL result modulo 2^XLEN (low XLEN bits only); no overflow flag.
REQ-022 SHALL drive stall = (IDLE & start & ~flush) | CALC; stall is low in DONE so the pipeline advances in the done cycle.
REQ-023 SHALL, on flush in CALC or DONE, go to IDLE next cycle, suppress done, and leave result unchanged.
REQ-024 SHALL give flush priority over start when both are high in IDLE (no acceptance, stall low).
REQ-025 SHALL hold result stable from the done cycle until the next done cycle.
REQ-026 SHALL accept a new start in the IDLE cycle immediately following DONE (back-to-back ops, one bubble).

Reset
REQ-027 SHALL, while rst is high, force state IDLE, counter 0, busy 0, stall 0, done 0, result 0 asynchronously, including mid-CALC.
REQ-028 SHALL ignore start, flush in any cycle where rst is high; first acceptance possible on the first edge after rst falls.

Verification
REQ-029 SHALL cover: MUL rs1=7 rs2=6 start at N -> stall high N..N+32, done at N+33, result 0x0000002A; MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
REQ-030 SHALL cover: DIVU 100/7 -> result 14 at N+33; REMU 100/7 -> result 2; DIVU 0x80000000/1 -> 0x80000000.
REQ-031 SHALL cover: DIVU 5/0 -> done at N+1, result 0xFFFFFFFF; REMU 5/0 -> result 5; op=11 -> done at N+1, result 0.
REQ-032 SHALL cover: flush at iteration 10 of MUL -> busy/stall low next cycle, no done, result keeps previous value; following MUL 3*3 -> 9.
REQ-033 SHALL cover: rst asserted mid-CALC (async, between edges) -> busy, stall, done, result 0 immediately; start ignored while rst high.
REQ-034 SHALL cover: start held high through CALC and DONE -> second op accepted only in IDLE after done; start+flush in IDLE -> not accepted.
